// File: rtl/lbist_pkg.sv
// Shared state encoding, signature width and Galois polynomial for the LBIST controller.
package lbist_pkg;

   localparam int unsigned SIG_W = 32;

   // x^32 + x^22 + x^2 + x + 1, x^32 term implicit in the shift-out bit
   localparam logic [SIG_W-1:0] LFSR_POLY = 32'h0040_0007;

   typedef enum logic [2:0] {
      StIdle,
      StSeed,
      StShift,
      StCapture,
      StUnload,
      StCompare,
      StPass,
      StFail
   } lbist_state_e;

   function automatic logic [SIG_W-1:0] galois_step(input logic [SIG_W-1:0] s);
      return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? LFSR_POLY : '0);
   endfunction

endpackage

// File: rtl/lbist_lfsr.sv
// 32-bit Galois register with synchronous load, step enable and parallel XOR input.
// Serves as the PRPG (data tied 0) and as the MISR.
module lbist_lfsr
   import lbist_pkg::*;
#(
   parameter logic [SIG_W-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [SIG_W-1:0] load_val_i,
   input  logic             en_i,
   input  logic [SIG_W-1:0] data_i,
   output logic [SIG_W-1:0] state_o
);

   logic [SIG_W-1:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = load_val_i;
      end else if (en_i) begin
         state_d = galois_step(state_q) ^ data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RESET_VAL;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/lbist_ctrl.sv
// Logic BIST controller: PRPG-driven scan shift/capture, MISR compaction, go/no-go verdict.
// Define LBIST_SIG_DEBUG_EN to add the signature_o debug port (live MISR value).
module lbist_ctrl
   import lbist_pkg::*;
#(
   parameter int unsigned SCAN_CHAINS = 8,
   parameter int unsigned CHAIN_LEN   = 64,
   parameter int unsigned N_PATTERNS  = 1024,
   parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001,
   parameter logic [31:0] GOLDEN_SIG  = 32'h0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   test_mode,
   output logic                   scan_en_o,
   output logic [SCAN_CHAINS-1:0] scan_in_o,
   input  logic [SCAN_CHAINS-1:0] scan_out_i,
   output logic                   go_nogo,
   output logic                   done_o
`ifdef LBIST_SIG_DEBUG_EN
   ,
   output logic [SIG_W-1:0]       signature_o
`endif
);

   localparam int unsigned SHIFT_W = $clog2(CHAIN_LEN);
   localparam int unsigned PAT_W   = $clog2(N_PATTERNS + 1);
   localparam logic [SHIFT_W-1:0] LAST_SHIFT = SHIFT_W'(CHAIN_LEN - 1);
   localparam logic [PAT_W-1:0]   LAST_PAT   = PAT_W'(N_PATTERNS - 1);

   if (LFSR_SEED == 32'h0) begin : g_bad_seed
      $fatal(1, "lbist_ctrl: LFSR_SEED must be non-zero");
   end
   if (SCAN_CHAINS < 1 || SCAN_CHAINS > 32) begin : g_bad_chains
      $fatal(1, "lbist_ctrl: SCAN_CHAINS must be 1..32");
   end

   lbist_state_e       state_q, state_d;
   logic               tm_prev_q, tm_prev_d;
   logic [SHIFT_W-1:0] shift_cnt_q, shift_cnt_d;
   logic [PAT_W-1:0]   pat_cnt_q, pat_cnt_d;
   logic [SIG_W-1:0]   prpg_state, misr_state;
   logic               in_run, tm_rise, misr_en;

   assign in_run  = state_q inside {StSeed, StShift, StCapture, StUnload, StCompare};
   assign tm_rise = test_mode & ~tm_prev_q;
   // Pattern 1 shift unloads the chains' pre-test contents, which are not compacted
   assign misr_en = (state_q == StUnload) || ((state_q == StShift) && (pat_cnt_q != '0));

   lbist_lfsr #(
      .RESET_VAL (LFSR_SEED)
   ) u_prpg (
      .clk        (clk),
      .rst        (rst),
      .load_i     (state_q == StSeed),
      .load_val_i (LFSR_SEED),
      .en_i       (state_q == StShift),
      .data_i     ('0),
      .state_o    (prpg_state)
   );

   lbist_lfsr #(
      .RESET_VAL ('0)
   ) u_misr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (state_q == StSeed),
      .load_val_i ('0),
      .en_i       (misr_en),
      .data_i     (SIG_W'(scan_out_i)),
      .state_o    (misr_state)
   );

   always_comb begin
      state_d     = state_q;
      tm_prev_d   = test_mode;
      shift_cnt_d = shift_cnt_q;
      pat_cnt_d   = pat_cnt_q;
      unique case (state_q)
         StIdle, StPass, StFail: begin
            if (tm_rise) state_d = StSeed;
         end
         StSeed: begin
            shift_cnt_d = '0;
            pat_cnt_d   = '0;
            state_d     = StShift;
         end
         StShift: begin
            if (shift_cnt_q == LAST_SHIFT) begin
               shift_cnt_d = '0;
               state_d     = StCapture;
            end else begin
               shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
            end
         end
         StCapture: begin
            pat_cnt_d = pat_cnt_q + PAT_W'(1);
            state_d   = (pat_cnt_q < LAST_PAT) ? StShift : StUnload;
         end
         StUnload: begin
            if (shift_cnt_q == LAST_SHIFT) begin
               shift_cnt_d = '0;
               state_d     = StCompare;
            end else begin
               shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
            end
         end
         StCompare: begin
            state_d = (misr_state == GOLDEN_SIG) ? StPass : StFail;
         end
         default: state_d = StIdle;
      endcase
      if (in_run && !test_mode) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         tm_prev_q   <= 1'b0;
         shift_cnt_q <= '0;
         pat_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         tm_prev_q   <= tm_prev_d;
         shift_cnt_q <= shift_cnt_d;
         pat_cnt_q   <= pat_cnt_d;
      end
   end

   always_comb begin
      scan_en_o = (state_q == StShift) || (state_q == StUnload);
      scan_in_o = (state_q == StShift) ? SCAN_CHAINS'(prpg_state) : '0;
      go_nogo   = (state_q == StPass);
      done_o    = (state_q == StPass) || (state_q == StFail);
   end

`ifdef LBIST_SIG_DEBUG_EN
   assign signature_o = misr_state;
`endif

endmodule

// File: tb/tb_lbist_ctrl.sv
// Self-checking bench for lbist_ctrl (2 chains x 4 flops, 2 patterns) against a run-level model.
// Exercises the signature_o port when LBIST_SIG_DEBUG_EN is defined.
`timescale 1ns/1ps
module tb_lbist_ctrl;

   localparam int SC = 2;
   localparam int CL = 4;
   localparam int NP = 2;
   localparam int CW = SC * CL;
   localparam logic [31:0] SEED = 32'hACE1_0001;
   localparam int RUN_LEN = 2 + NP * (CL + 1) + CL;
   localparam int UNL_K   = NP * (CL + 1) + 1;

   function automatic logic [31:0] step(input logic [31:0] s);
      return (s << 1) ^ (s[31] ? 32'h0040_0007 : 32'h0);
   endfunction

   function automatic bit is_shift(input int k);
      return (k >= 1) && (k <= NP * (CL + 1)) && (((k - 1) % (CL + 1)) < CL);
   endfunction

   function automatic bit is_unl(input int k);
      return (k >= UNL_K) && (k < UNL_K + CL);
   endfunction

   // Whole-run signature with chains looped back; capture inverts every flop.
   function automatic logic [31:0] loop_sig(input int flip_k, input int flip_c);
      logic [31:0]   misr;
      logic [31:0]   prpg;
      logic [CW-1:0] st;
      logic [SC-1:0] sout;
      int            k;
      misr = 32'h0;
      prpg = SEED;
      st   = '0;
      k    = 1;
      for (int p = 0; p <= NP; p++) begin
         for (int t = 0; t < CL; t++) begin
            sout = st[CW-1 -: SC];
            if (k == flip_k) sout[flip_c] = ~sout[flip_c];
            if (p > 0) misr = step(misr) ^ 32'(sout);
            st = {st[CW-SC-1:0], (p < NP) ? prpg[SC-1:0] : {SC{1'b0}}};
            if (p < NP) prpg = step(prpg);
            k++;
         end
         st = ~st;
         k++;
      end
      return misr;
   endfunction

   localparam logic [31:0] GOLDEN_LB = loop_sig(-1, 0);

   logic clk = 1'b0;
   logic rst, tm0, tm1;
   logic scan_en0, scan_en1, go0, go1, done0, done1;
   logic [SC-1:0] scan_in0, scan_in1, so0, so1, flip1;
   logic [CW-1:0] chain_q, chain_init;
   logic chain_load;
   logic [31:0] m_misr;
   int vectors = 0;
   int miscompares = 0;
`ifdef LBIST_SIG_DEBUG_EN
   logic [31:0] sig0, sig1;
`endif

   always #5 clk = ~clk;

   lbist_ctrl #(
      .SCAN_CHAINS (SC), .CHAIN_LEN (CL), .N_PATTERNS (NP),
      .LFSR_SEED (SEED), .GOLDEN_SIG (32'h0)
   ) dut0 (
      .clk (clk), .rst (rst), .test_mode (tm0), .scan_en_o (scan_en0),
      .scan_in_o (scan_in0), .scan_out_i (so0), .go_nogo (go0), .done_o (done0)
`ifdef LBIST_SIG_DEBUG_EN
      , .signature_o (sig0)
`endif
   );

   lbist_ctrl #(
      .SCAN_CHAINS (SC), .CHAIN_LEN (CL), .N_PATTERNS (NP),
      .LFSR_SEED (SEED), .GOLDEN_SIG (GOLDEN_LB)
   ) dut1 (
      .clk (clk), .rst (rst), .test_mode (tm1), .scan_en_o (scan_en1),
      .scan_in_o (scan_in1), .scan_out_i (so1), .go_nogo (go1), .done_o (done1)
`ifdef LBIST_SIG_DEBUG_EN
      , .signature_o (sig1)
`endif
   );

   // Scan chains seen by dut1: shift when enabled, otherwise functional capture (invert)
   always @(posedge clk) begin
      if (chain_load) chain_q <= chain_init;
      else if (scan_en1) chain_q <= {chain_q[CW-SC-1:0], scan_in1};
      else chain_q <= ~chain_q;
   end
   assign so1 = chain_q[CW-1 -: SC] ^ flip1;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle0(input int n);
      tm0 = 1'b0;
      repeat (n) tick();
   endtask

   // One dut0 run from the edge entering SEED; optional abort at cycle drop_k.
   task automatic run0(input int drop_k, input bit rand_so);
      logic [31:0] prpg, misr;
      bit sh, un, fin;
      prpg = SEED;
      misr = 32'h0;
      tm0  = 1'b1;
      for (int k = 0; k <= RUN_LEN; k++) begin
         tick();
         sh  = is_shift(k);
         un  = is_unl(k);
         fin = (k == RUN_LEN);
         vectors++;
         if (scan_en0 !== (sh || un)) begin
            miscompares++;
            $display("FAIL run0_scan_en k=%0d got %b want %b", k, scan_en0, sh || un);
         end
         vectors++;
         if (scan_in0 !== (sh ? prpg[SC-1:0] : {SC{1'b0}})) begin
            miscompares++;
            $display("FAIL run0_scan_in k=%0d got %b want %b", k, scan_in0,
                     sh ? prpg[SC-1:0] : {SC{1'b0}});
         end
         vectors++;
         if ({done0, go0} !== {fin, fin && (misr == 32'h0)}) begin
            miscompares++;
            $display("FAIL run0_done_go k=%0d got %b%b want %b%b", k, done0, go0, fin,
                     fin && (misr == 32'h0));
         end
`ifdef LBIST_SIG_DEBUG_EN
         if (k > 0) begin
            vectors++;
            if (sig0 !== misr) begin
               miscompares++;
               $display("FAIL run0_signature k=%0d got %h want %h", k, sig0, misr);
            end
         end
`endif
         if (sh) prpg = step(prpg);
         so0 = rand_so ? SC'($urandom) : {SC{1'b0}};
         if ((sh && k > CL) || un) misr = step(misr) ^ 32'(so0);
         if (k == drop_k) begin
            tm0 = 1'b0;
            tick();
            vectors++;
            if ({scan_en0, done0, go0} !== 3'b000) begin
               miscompares++;
               $display("FAIL abort k=%0d got en/done/go %b%b%b want 000", k, scan_en0,
                        done0, go0);
            end
            return;
         end
      end
      m_misr = misr;
   endtask

   task automatic run1(input int flip_k, input int flip_c);
      logic [31:0] want;
      want = loop_sig(flip_k, flip_c);
      tm1  = 1'b1;
      for (int k = 0; k <= RUN_LEN; k++) begin
         tick();
         vectors++;
         if (scan_en1 !== (is_shift(k) || is_unl(k))) begin
            miscompares++;
            $display("FAIL run1_scan_en k=%0d got %b want %b", k, scan_en1,
                     is_shift(k) || is_unl(k));
         end
         if (k >= RUN_LEN - 1) begin
            vectors++;
            if ({done1, go1} !== {k == RUN_LEN, (k == RUN_LEN) && (want == GOLDEN_LB)}) begin
               miscompares++;
               $display("FAIL run1_verdict k=%0d flip_k=%0d got %b%b want %b%b", k, flip_k,
                        done1, go1, k == RUN_LEN, (k == RUN_LEN) && (want == GOLDEN_LB));
            end
         end
         flip1 = '0;
         if (k == flip_k) flip1[flip_c] = 1'b1;
      end
      flip1 = '0;
`ifdef LBIST_SIG_DEBUG_EN
      vectors++;
      if (sig1 !== want) begin
         miscompares++;
         $display("FAIL run1_signature got %h want %h", sig1, want);
      end
`endif
      tm1 = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tm0 = 1'b1;
      repeat (3) tick();
      vectors++;
      if ({scan_en0, scan_in0, go0, done0} !== '0) begin
         miscompares++;
         $display("FAIL reset_dut0 got %b want 0", {scan_en0, scan_in0, go0, done0});
      end
      vectors++;
      if ({scan_en1, scan_in1, go1, done1} !== '0) begin
         miscompares++;
         $display("FAIL reset_dut1 got %b want 0", {scan_en1, scan_in1, go1, done1});
      end
      rst        = 1'b0;
      chain_load = 1'b0;
   endtask

   // test_mode held high through reset release starts a run; then PASS must hold
   task automatic test_zero_pass();
      run0(-1, 1'b0);
      repeat (2) begin
         tick();
         vectors++;
         if ({done0, go0} !== 2'b11) begin
            miscompares++;
            $display("FAIL pass_hold got %b%b want 11", done0, go0);
         end
      end
   endtask

   task automatic test_rerun();
      idle0(0);
      repeat (3) begin
         tick();
         vectors++;
         if ({done0, go0} !== 2'b11) begin
            miscompares++;
            $display("FAIL pass_after_fall got %b%b want 11", done0, go0);
         end
      end
      run0(-1, 1'b0);
   endtask

   task automatic test_abort();
      idle0(1);
      run0(6, 1'b0);
      idle0(1);
      run0(-1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle0(1);
         run0(int'($urandom_range(0, RUN_LEN - 1)), 1'b1);
      end
   endtask

   task automatic test_rst_mid();
      idle0(1);
      tm0 = 1'b1;
      repeat (4) tick();
      vectors++;
      if (scan_en0 !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_pre got %b want 1", scan_en0);
      end
      rst = 1'b1;
      tick();
      vectors++;
      if ({scan_en0, scan_in0, go0, done0} !== '0) begin
         miscompares++;
         $display("FAIL rst_mid got %b want 0", {scan_en0, scan_in0, go0, done0});
      end
      rst = 1'b0;
      run0(-1, 1'b0);
   endtask

   task automatic test_random_sig();
      for (int i = 0; i < 4; i++) begin
         idle0(int'($urandom_range(1, 3)));
         run0(-1, 1'b1);
         tm0 = 1'b0;
         repeat (2) begin
            tick();
            vectors++;
            if ({done0, go0} !== {1'b1, m_misr == 32'h0}) begin
               miscompares++;
               $display("FAIL random_hold got %b%b want 1%b", done0, go0, m_misr == 32'h0);
            end
`ifdef LBIST_SIG_DEBUG_EN
            vectors++;
            if (sig0 !== m_misr) begin
               miscompares++;
               $display("FAIL random_sig_frozen got %h want %h", sig0, m_misr);
            end
`endif
         end
      end
   endtask

   task automatic test_loopback();
      run1(-1, 0);
      run1(-1, 0);
   endtask

   task automatic test_flip();
      for (int i = 0; i < 3; i++) begin
         run1(int'($urandom_range(CL + 2, 2 * CL + 1)), int'($urandom_range(0, SC - 1)));
      end
      run1(int'($urandom_range(1, CL)), int'($urandom_range(0, SC - 1)));
      run1(int'($urandom_range(UNL_K, UNL_K + CL - 1)), int'($urandom_range(0, SC - 1)));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      tm0        = 1'b0;
      tm1        = 1'b0;
      so0        = '0;
      flip1      = '0;
      m_misr     = 32'h0;
      chain_load = 1'b1;
      chain_init = CW'($urandom);
      test_reset();
      test_zero_pass();
      test_rerun();
      test_abort();
      test_rst_mid();
      test_random_sig();
      test_loopback();
      test_flip();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
